// File: rtl/control_unit_pkg.sv
// Shared encodings for the ID-stage control unit: opcodes, control-field codes,
// enable names and the bubble (NOP) control word.
package control_unit_pkg;

   localparam logic [6:0] LUI_OPCODE    = 7'b0110111;
   localparam logic [6:0] AUIPC_OPCODE  = 7'b0010111;
   localparam logic [6:0] JAL_OPCODE    = 7'b1101111;
   localparam logic [6:0] JALR_OPCODE   = 7'b1100111;
   localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;
   localparam logic [6:0] LOAD_OPCODE   = 7'b0000011;
   localparam logic [6:0] STORE_OPCODE  = 7'b0100011;
   localparam logic [6:0] OP_IMM_OPCODE = 7'b0010011;
   localparam logic [6:0] OP_OPCODE     = 7'b0110011;

   localparam logic OP1SEL_RS1     = 1'b0;
   localparam logic OP1SEL_PC      = 1'b1;
   localparam logic OP2SEL_RS2     = 1'b0;
   localparam logic OP2SEL_IMM     = 1'b1;
   localparam logic MEM_WRITE_0    = 1'b0;
   localparam logic MEM_WRITE_1    = 1'b1;
   localparam logic MEM_READ_0     = 1'b0;
   localparam logic MEM_READ_1     = 1'b1;
   localparam logic REG_WRITE_EN_0 = 1'b0;
   localparam logic REG_WRITE_EN_1 = 1'b1;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_IMM = 2'b10,
      WB_PC4 = 2'b11
   } wb_sel_t;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_MUL    = 5'd10,
      ALU_MULH   = 5'd11,
      ALU_MULHSU = 5'd12,
      ALU_MULHU  = 5'd13,
      ALU_DIV    = 5'd14,
      ALU_DIVU   = 5'd15,
      ALU_REM    = 5'd16,
      ALU_REMU   = 5'd17
   } alu_op_t;

   typedef enum logic [2:0] {
      BJ_NO   = 3'b000,
      BJ_J    = 3'b001,
      BJ_BEQ  = 3'b010,
      BJ_BNE  = 3'b011,
      BJ_BLT  = 3'b100,
      BJ_BGE  = 3'b101,
      BJ_BLTU = 3'b110,
      BJ_BGEU = 3'b111
   } branch_jump_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_sel_t;

   // Which ALU-op table the sub-decoder should consult for this opcode.
   typedef enum logic [1:0] {
      CLS_OTHER  = 2'b00,
      CLS_OP_IMM = 2'b01,
      CLS_OP     = 2'b10
   } alu_class_t;

   typedef enum logic [1:0] {
      F7_OTHER  = 2'b00,
      F7_BASE   = 2'b01,
      F7_ALT    = 2'b10,
      F7_MULDIV = 2'b11
   } f7_kind_t;

   typedef struct packed {
      logic         op1sel;
      logic         op2sel;
      logic         mem_write;
      logic         mem_read;
      logic         reg_write_en;
      wb_sel_t      wb_sel;
      alu_op_t      alu_op;
      branch_jump_t branch_jump;
      imm_sel_t     imm_sel;
   } ctrl_t;

   localparam ctrl_t BUBBLE_CTRL = '{
      op1sel:       OP1SEL_RS1,
      op2sel:       OP2SEL_RS2,
      mem_write:    MEM_WRITE_0,
      mem_read:     MEM_READ_0,
      reg_write_en: REG_WRITE_EN_0,
      wb_sel:       WB_ALU,
      alu_op:       ALU_ADD,
      branch_jump:  BJ_NO,
      imm_sel:      IMM_I
   };

   function automatic f7_kind_t classify_funct7(input logic [6:0] funct7);
      f7_kind_t kind;
      kind = F7_OTHER;
      case (funct7)
         7'b0000000: kind = F7_BASE;
         7'b0100000: kind = F7_ALT;
         7'b0000001: kind = F7_MULDIV;
         default:    kind = F7_OTHER;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/control_unit_alu_op_decoder.sv
// Maps (opcode class, FUNCT3, FUNCT7) to an ALU operation and an illegal flag.
// M-extension decodes are compiled in only when RV32M_EN is defined.
module alu_op_decoder
   import control_unit_pkg::*;
(
   input  logic [1:0] op_class,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [4:0] alu_op,
   output logic       illegal
);

   alu_op_t  base_op;
   logic     base_ok;
   alu_op_t  op;
   f7_kind_t f7_kind;

   assign f7_kind = classify_funct7(funct7);

   // NOTE: every variable driven here gets a default first so no path can infer a latch.
   always_comb begin
      base_op = ALU_ADD;
      base_ok = 1'b1;
      case (funct3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         3'b111:  base_op = ALU_AND;
         default: base_ok = 1'b0;
      endcase
   end

   always_comb begin
      op      = ALU_ADD;
      illegal = 1'b0;
      case (op_class)
         CLS_OP_IMM: begin
            // Only the shift-immediates constrain FUNCT7; unknown FUNCT3 falls to base_ok.
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               case (f7_kind)
                  F7_BASE: op = base_op;
                  F7_ALT: begin
                     if (funct3 == 3'b101) op = ALU_SRA;
                     else                  illegal = 1'b1;
                  end
                  default: illegal = 1'b1;
               endcase
            end else begin
               op      = base_op;
               illegal = !base_ok;
            end
         end
         CLS_OP: begin
            case (f7_kind)
               F7_BASE: begin
                  op      = base_op;
                  illegal = !base_ok;
               end
               F7_ALT: begin
                  case (funct3)
                     3'b000:  op = ALU_SUB;
                     3'b101:  op = ALU_SRA;
                     default: illegal = 1'b1;
                  endcase
               end
               F7_MULDIV: begin
`ifdef RV32M_EN
                  case (funct3)
                     3'b000:  op = ALU_MUL;
                     3'b001:  op = ALU_MULH;
                     3'b010:  op = ALU_MULHSU;
                     3'b011:  op = ALU_MULHU;
                     3'b100:  op = ALU_DIV;
                     3'b101:  op = ALU_DIVU;
                     3'b110:  op = ALU_REM;
                     3'b111:  op = ALU_REMU;
                     default: illegal = 1'b1;
                  endcase
`else
                  illegal = 1'b1;
`endif
               end
               default: illegal = 1'b1;
            endcase
         end
         default: op = ALU_ADD;
      endcase
   end

   assign alu_op = op;

endmodule

// File: rtl/control_unit.sv
// ID-stage registered instruction decoder for the RV32IM pipeline (ID/EX control register).
// Define RV32M_EN to enable decoding of the M-extension (FUNCT7=0000001) OP instructions.
module control_unit
   import control_unit_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic [6:0] OPCODE,
   input  logic [2:0] FUNCT3,
   input  logic [6:0] FUNCT7,
   output logic       OP1SEL,
   output logic       OP2SEL,
   output logic       MEM_WRITE,
   output logic       MEM_READ,
   output logic       REG_WRITE_EN,
   output logic [1:0] WB_SEL,
   output logic [4:0] ALU_OP,
   output logic [2:0] BRANCH_JUMP,
   output logic [2:0] IMM_SEL
);

   alu_class_t alu_class;
   logic [4:0] alu_dec;
   logic       alu_illegal;
   ctrl_t      dec;
   ctrl_t      ctrl_q;

   always_comb begin
      alu_class = CLS_OTHER;
      case (OPCODE)
         OP_IMM_OPCODE: alu_class = CLS_OP_IMM;
         OP_OPCODE:     alu_class = CLS_OP;
         default:       alu_class = CLS_OTHER;
      endcase
   end

   alu_op_decoder u_alu_op_decoder (
      .op_class (alu_class),
      .funct3   (FUNCT3),
      .funct7   (FUNCT7),
      .alu_op   (alu_dec),
      .illegal  (alu_illegal)
   );

   // NOTE: combinational decode uses blocking '=' so later fields see earlier ones this pass.
   always_comb begin
      dec = BUBBLE_CTRL;
      case (OPCODE)
         LUI_OPCODE: begin
            dec.reg_write_en = REG_WRITE_EN_1;
            dec.wb_sel       = WB_IMM;
            dec.imm_sel      = IMM_U;
            dec.op2sel       = OP2SEL_IMM;
         end
         AUIPC_OPCODE: begin
            dec.op1sel       = OP1SEL_PC;
            dec.op2sel       = OP2SEL_IMM;
            dec.imm_sel      = IMM_U;
            dec.reg_write_en = REG_WRITE_EN_1;
         end
         JAL_OPCODE: begin
            dec.op1sel       = OP1SEL_PC;
            dec.op2sel       = OP2SEL_IMM;
            dec.wb_sel       = WB_PC4;
            dec.branch_jump  = BJ_J;
            dec.imm_sel      = IMM_J;
            dec.reg_write_en = REG_WRITE_EN_1;
         end
         JALR_OPCODE: begin
            case (FUNCT3)
               3'b000: begin
                  dec.op2sel       = OP2SEL_IMM;
                  dec.wb_sel       = WB_PC4;
                  dec.branch_jump  = BJ_J;
                  dec.reg_write_en = REG_WRITE_EN_1;
               end
               default: dec = BUBBLE_CTRL;
            endcase
         end
         BRANCH_OPCODE: begin
            case (FUNCT3)
               3'b000:  dec.branch_jump = BJ_BEQ;
               3'b001:  dec.branch_jump = BJ_BNE;
               3'b100:  dec.branch_jump = BJ_BLT;
               3'b101:  dec.branch_jump = BJ_BGE;
               3'b110:  dec.branch_jump = BJ_BLTU;
               3'b111:  dec.branch_jump = BJ_BGEU;
               default: dec.branch_jump = BJ_NO;
            endcase
            // Target address is PC + B-immediate; illegal FUNCT3 leaves the bubble intact.
            if (dec.branch_jump != BJ_NO) begin
               dec.op1sel  = OP1SEL_PC;
               dec.op2sel  = OP2SEL_IMM;
               dec.imm_sel = IMM_B;
            end
         end
         LOAD_OPCODE: begin
            case (FUNCT3)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
                  dec.op2sel       = OP2SEL_IMM;
                  dec.mem_read     = MEM_READ_1;
                  dec.wb_sel       = WB_MEM;
                  dec.reg_write_en = REG_WRITE_EN_1;
               end
               default: dec = BUBBLE_CTRL;
            endcase
         end
         STORE_OPCODE: begin
            case (FUNCT3)
               3'b000, 3'b001, 3'b010: begin
                  dec.op2sel    = OP2SEL_IMM;
                  dec.mem_write = MEM_WRITE_1;
                  dec.imm_sel   = IMM_S;
               end
               default: dec = BUBBLE_CTRL;
            endcase
         end
         OP_IMM_OPCODE: begin
            if (!alu_illegal) begin
               dec.op2sel       = OP2SEL_IMM;
               dec.alu_op       = alu_op_t'(alu_dec);
               dec.reg_write_en = REG_WRITE_EN_1;
            end
         end
         OP_OPCODE: begin
            if (!alu_illegal) begin
               dec.alu_op       = alu_op_t'(alu_dec);
               dec.reg_write_en = REG_WRITE_EN_1;
            end
         end
         default: dec = BUBBLE_CTRL;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so all fields update together at the edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) ctrl_q <= BUBBLE_CTRL;
      else       ctrl_q <= dec;
   end

   assign OP1SEL       = ctrl_q.op1sel;
   assign OP2SEL       = ctrl_q.op2sel;
   assign MEM_WRITE    = ctrl_q.mem_write;
   assign MEM_READ     = ctrl_q.mem_read;
   assign REG_WRITE_EN = ctrl_q.reg_write_en;
   assign WB_SEL       = ctrl_q.wb_sel;
   assign ALU_OP       = ctrl_q.alu_op;
   assign BRANCH_JUMP  = ctrl_q.branch_jump;
   assign IMM_SEL      = ctrl_q.imm_sel;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: reset/latency sequences plus a directed decode table.
module tb_control_unit;

   logic       CLK;
   logic       RESET;
   logic [6:0] OPCODE;
   logic [2:0] FUNCT3;
   logic [6:0] FUNCT7;
   logic       OP1SEL, OP2SEL, MEM_WRITE, MEM_READ, REG_WRITE_EN;
   logic [1:0] WB_SEL;
   logic [4:0] ALU_OP;
   logic [2:0] BRANCH_JUMP;
   logic [2:0] IMM_SEL;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [17:0] exp;
   } vec_t;

   vec_t vecs[$];

   control_unit dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .OPCODE       (OPCODE),
      .FUNCT3       (FUNCT3),
      .FUNCT7       (FUNCT7),
      .OP1SEL       (OP1SEL),
      .OP2SEL       (OP2SEL),
      .MEM_WRITE    (MEM_WRITE),
      .MEM_READ     (MEM_READ),
      .REG_WRITE_EN (REG_WRITE_EN),
      .WB_SEL       (WB_SEL),
      .ALU_OP       (ALU_OP),
      .BRANCH_JUMP  (BRANCH_JUMP),
      .IMM_SEL      (IMM_SEL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Fields: op1sel, op2sel, mem_write, mem_read, reg_write_en, wb_sel, alu_op, branch_jump, imm_sel
   function automatic logic [17:0] mk(input logic o1, input logic o2, input logic mw,
                                      input logic mr, input logic rwe, input logic [1:0] wb,
                                      input logic [4:0] alu, input logic [2:0] bj,
                                      input logic [2:0] im);
      return {o1, o2, mw, mr, rwe, wb, alu, bj, im};
   endfunction

   function automatic logic [17:0] outs();
      return {OP1SEL, OP2SEL, MEM_WRITE, MEM_READ, REG_WRITE_EN, WB_SEL, ALU_OP, BRANCH_JUMP, IMM_SEL};
   endfunction

   task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%b required=%b", name, got, exp);
      end
   endtask

   task automatic add(input string name, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [17:0] exp);
      vec_t v;
      v.name = name; v.opcode = op; v.funct3 = f3; v.funct7 = f7; v.exp = exp;
      vecs.push_back(v);
   endtask

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                          JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                          ST = 7'b0100011, OPI = 7'b0010011, OPR = 7'b0110011;
   localparam logic [6:0] F7Z = 7'b0000000, F7A = 7'b0100000, F7M = 7'b0000001;

   logic [17:0] bubble, lui_e, jal_e, div_e;

   initial begin
      bubble = mk(0, 0, 0, 0, 0, 2'b00, 5'd0, 3'b000, 3'b000);
      lui_e  = mk(0, 1, 0, 0, 1, 2'b10, 5'd0, 3'b000, 3'b011);
      jal_e  = mk(1, 1, 0, 0, 1, 2'b11, 5'd0, 3'b001, 3'b100);
`ifdef RV32M_EN
      div_e  = mk(0, 0, 0, 0, 1, 2'b00, 5'd14, 3'b000, 3'b000);
`else
      div_e  = bubble;
`endif

      add("lui",       LUI,   3'b000, F7Z, lui_e);
      add("auipc",     AUIPC, 3'b101, F7Z, mk(1, 1, 0, 0, 1, 2'b00, 5'd0, 3'b000, 3'b011));
      add("jal",       JAL,   3'b000, F7Z, jal_e);
      add("jalr",      JALR,  3'b000, F7Z, mk(0, 1, 0, 0, 1, 2'b11, 5'd0, 3'b001, 3'b000));
      add("jalr_f3",   JALR,  3'b001, F7Z, bubble);
      add("beq",       BR,    3'b000, F7Z, mk(1, 1, 0, 0, 0, 2'b00, 5'd0, 3'b010, 3'b010));
      add("bne",       BR,    3'b001, F7Z, mk(1, 1, 0, 0, 0, 2'b00, 5'd0, 3'b011, 3'b010));
      add("br_010",    BR,    3'b010, F7Z, bubble);
      add("br_011",    BR,    3'b011, F7Z, bubble);
      add("blt",       BR,    3'b100, F7Z, mk(1, 1, 0, 0, 0, 2'b00, 5'd0, 3'b100, 3'b010));
      add("bge",       BR,    3'b101, F7Z, mk(1, 1, 0, 0, 0, 2'b00, 5'd0, 3'b101, 3'b010));
      add("bltu",      BR,    3'b110, F7Z, mk(1, 1, 0, 0, 0, 2'b00, 5'd0, 3'b110, 3'b010));
      add("bgeu",      BR,    3'b111, F7Z, mk(1, 1, 0, 0, 0, 2'b00, 5'd0, 3'b111, 3'b010));
      add("lw",        LD,    3'b010, F7Z, mk(0, 1, 0, 1, 1, 2'b01, 5'd0, 3'b000, 3'b000));
      add("lbu",       LD,    3'b100, F7A, mk(0, 1, 0, 1, 1, 2'b01, 5'd0, 3'b000, 3'b000));
      add("load_011",  LD,    3'b011, F7Z, bubble);
      add("sw",        ST,    3'b010, F7Z, mk(0, 1, 1, 0, 0, 2'b00, 5'd0, 3'b000, 3'b001));
      add("store_100", ST,    3'b100, F7Z, bubble);
      add("addi",      OPI,   3'b000, 7'h55, mk(0, 1, 0, 0, 1, 2'b00, 5'd0, 3'b000, 3'b000));
      add("sltiu",     OPI,   3'b011, F7Z, mk(0, 1, 0, 0, 1, 2'b00, 5'd4, 3'b000, 3'b000));
      add("slli",      OPI,   3'b001, F7Z, mk(0, 1, 0, 0, 1, 2'b00, 5'd2, 3'b000, 3'b000));
      add("slli_bad",  OPI,   3'b001, F7A, bubble);
      add("srli",      OPI,   3'b101, F7Z, mk(0, 1, 0, 0, 1, 2'b00, 5'd6, 3'b000, 3'b000));
      add("srai",      OPI,   3'b101, F7A, mk(0, 1, 0, 0, 1, 2'b00, 5'd7, 3'b000, 3'b000));
      add("srai_bad",  OPI,   3'b101, F7M, bubble);
      add("add",       OPR,   3'b000, F7Z, mk(0, 0, 0, 0, 1, 2'b00, 5'd0, 3'b000, 3'b000));
      add("sub",       OPR,   3'b000, F7A, mk(0, 0, 0, 0, 1, 2'b00, 5'd1, 3'b000, 3'b000));
      add("sra",       OPR,   3'b101, F7A, mk(0, 0, 0, 0, 1, 2'b00, 5'd7, 3'b000, 3'b000));
      add("op_001_alt",OPR,   3'b001, F7A, bubble);
      add("and",       OPR,   3'b111, F7Z, mk(0, 0, 0, 0, 1, 2'b00, 5'd9, 3'b000, 3'b000));
      add("op_f7_bad", OPR,   3'b000, 7'b0000010, bubble);
      add("div",       OPR,   3'b100, F7M, div_e);
      add("bad_opc",   7'b1111111, 3'b000, F7Z, bubble);

      // Reset held: outputs stay at bubble while LUI toggles with other opcodes.
      RESET = 1'b1; OPCODE = LUI; FUNCT3 = 3'b000; FUNCT7 = F7Z;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         check($sformatf("reset_hold_%0d", i), outs(), bubble);
         OPCODE = (i % 2 == 0) ? JAL : LUI;
      end
      @(negedge CLK);
      OPCODE = LUI; RESET = 1'b0;
      #1 check("reset_released_no_edge", outs(), bubble);
      @(posedge CLK); #1;
      check("first_edge_lui", outs(), lui_e);

      // Inputs changing between edges must not reach the outputs until the edge.
      #2 OPCODE = JAL;
      #1 check("mid_cycle_hold", outs(), lui_e);
      @(posedge CLK); #1;
      check("next_edge_jal", outs(), jal_e);

      // Asynchronous reset mid-cycle clears outputs without a clock edge.
      #2 RESET = 1'b1;
      #1 check("async_reset", outs(), bubble);
      @(posedge CLK); #1;
      check("async_reset_hold", outs(), bubble);
      @(negedge CLK) RESET = 1'b0;

      foreach (vecs[i]) begin
         @(negedge CLK);
         OPCODE = vecs[i].opcode; FUNCT3 = vecs[i].funct3; FUNCT7 = vecs[i].funct7;
         @(posedge CLK); #1;
         check(vecs[i].name, outs(), vecs[i].exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
